// File: rtl/tcb_arb_3mp.sv
// TCB arbiter: three managers share one subordinate with grant lock under backpressure and delayed response routing.
// Build option: define TCB_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (port 0 highest).
module tcb_arb_3mp #(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int BW  = DW/8,
    parameter int DLY = 1,
    parameter int PN  = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sub0_vld,
    input  logic          sub0_wen,
    input  logic [BW-1:0] sub0_ben,
    input  logic [AW-1:0] sub0_adr,
    input  logic [DW-1:0] sub0_wdt,
    output logic [DW-1:0] sub0_rdt,
    output logic          sub0_err,
    output logic          sub0_rdy,
    input  logic          sub1_vld,
    input  logic          sub1_wen,
    input  logic [BW-1:0] sub1_ben,
    input  logic [AW-1:0] sub1_adr,
    input  logic [DW-1:0] sub1_wdt,
    output logic [DW-1:0] sub1_rdt,
    output logic          sub1_err,
    output logic          sub1_rdy,
    input  logic          sub2_vld,
    input  logic          sub2_wen,
    input  logic [BW-1:0] sub2_ben,
    input  logic [AW-1:0] sub2_adr,
    input  logic [DW-1:0] sub2_wdt,
    output logic [DW-1:0] sub2_rdt,
    output logic          sub2_err,
    output logic          sub2_rdy,
    output logic          man_vld,
    output logic          man_wen,
    output logic [BW-1:0] man_ben,
    output logic [AW-1:0] man_adr,
    output logic [DW-1:0] man_wdt,
    input  logic [DW-1:0] man_rdt,
    input  logic          man_err,
    input  logic          man_rdy
);

    if ((DLY < 1) || (DLY > 4)) begin : g_dly_chk
        $error("tcb_arb_3mp: DLY must be in 1..4");
    end
    if (BW != DW/8) begin : g_bw_chk
        $error("tcb_arb_3mp: BW must equal DW/8");
    end
    if (PN != 3) begin : g_pn_chk
        $error("tcb_arb_3mp: PN is fixed at 3");
    end

    // (a + b) mod 3 for port indices; index 3 is never produced
    function automatic logic [1:0] mod3_add(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
    endfunction

    logic [2:0] req_s;
    logic [2:0] rot_s;
    logic [1:0] base_s;
    logic [1:0] off_s;
    logic       found_s;
    logic [1:0] gnt_idx_s;
    logic [2:0] gnt_s;
    logic       trn_s;
    logic       lck_r;
    logic [1:0] lck_sel_r;
    logic [DLY-1:0] rsp_vld_r;
    logic [1:0]     rsp_sel_r [DLY];
    logic [2:0]     rsp_hit_s;

    assign req_s = {sub2_vld, sub1_vld, sub0_vld};
    assign trn_s = man_vld & man_rdy;

`ifdef TCB_ARB_RR_EN
    logic [1:0] ptr_r;

    // rotate requests so bit k is port (ptr + k) mod 3
    always_comb begin
        base_s = ptr_r;
        case (ptr_r)
            2'd0:    rot_s = req_s;
            2'd1:    rot_s = {req_s[0], req_s[2], req_s[1]};
            2'd2:    rot_s = {req_s[1], req_s[0], req_s[2]};
            default: rot_s = req_s;
        endcase
    end

    // round-robin pointer moves past the port that just transferred
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= 2'd0;
        end else if (trn_s) begin
            ptr_r <= mod3_add(gnt_idx_s, 2'd1);
        end
    end
`else
    // fixed priority: search always starts at port 0
    always_comb begin
        base_s = 2'd0;
        rot_s  = req_s;
    end
`endif

    // priority-encode the rotated request vector; a held lock overrides the search
    always_comb begin
        off_s     = 2'd0;
        found_s   = 1'b0;
        gnt_idx_s = 2'd0;
        gnt_s     = 3'b000;
        if (rot_s[0]) begin
            off_s   = 2'd0;
            found_s = 1'b1;
        end else if (rot_s[1]) begin
            off_s   = 2'd1;
            found_s = 1'b1;
        end else if (rot_s[2]) begin
            off_s   = 2'd2;
            found_s = 1'b1;
        end else begin
            found_s = 1'b0;
        end
        if (lck_r) begin
            gnt_idx_s = lck_sel_r;
            gnt_s     = 3'b001 << lck_sel_r;
        end else if (found_s) begin
            gnt_idx_s = mod3_add(base_s, off_s);
            gnt_s     = 3'b001 << gnt_idx_s;
        end else begin
            gnt_idx_s = 2'd0;
            gnt_s     = 3'b000;
        end
    end

    // forward the granted request; idle bus is driven to zero rather than X
    always_comb begin
        man_vld = |(req_s & gnt_s);
        man_wen = 1'b0;
        man_ben = '0;
        man_adr = '0;
        man_wdt = '0;
        if (man_vld) begin
            case (gnt_idx_s)
                2'd0: begin
                    man_wen = sub0_wen; man_ben = sub0_ben; man_adr = sub0_adr; man_wdt = sub0_wdt;
                end
                2'd1: begin
                    man_wen = sub1_wen; man_ben = sub1_ben; man_adr = sub1_adr; man_wdt = sub1_wdt;
                end
                2'd2: begin
                    man_wen = sub2_wen; man_ben = sub2_ben; man_adr = sub2_adr; man_wdt = sub2_wdt;
                end
                default: begin
                    man_wen = 1'b0; man_ben = '0; man_adr = '0; man_wdt = '0;
                end
            endcase
        end else begin
            man_wen = 1'b0;
        end
    end

    assign sub0_rdy = man_rdy & gnt_s[0];
    assign sub1_rdy = man_rdy & gnt_s[1];
    assign sub2_rdy = man_rdy & gnt_s[2];

    // lock holds the grant while the subordinate stalls; a dropped request also releases it
    always_ff @(posedge clk) begin
        if (rst) begin
            lck_r     <= 1'b0;
            lck_sel_r <= 2'd0;
        end else begin
            lck_r <= man_vld & ~man_rdy;
            if (man_vld & ~man_rdy) begin
                lck_sel_r <= gnt_idx_s;
            end
        end
    end

    // one response-tracking entry per cycle, valid only for cycles with a transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_vld_r <= '0;
            for (int i = 0; i < DLY; i++) begin
                rsp_sel_r[i] <= 2'd0;
            end
        end else begin
            rsp_vld_r[0] <= trn_s;
            rsp_sel_r[0] <= gnt_idx_s;
            for (int i = 1; i < DLY; i++) begin
                rsp_vld_r[i] <= rsp_vld_r[i-1];
                rsp_sel_r[i] <= rsp_sel_r[i-1];
            end
        end
    end

    assign rsp_hit_s[0] = rsp_vld_r[DLY-1] & (rsp_sel_r[DLY-1] == 2'd0);
    assign rsp_hit_s[1] = rsp_vld_r[DLY-1] & (rsp_sel_r[DLY-1] == 2'd1);
    assign rsp_hit_s[2] = rsp_vld_r[DLY-1] & (rsp_sel_r[DLY-1] == 2'd2);

    assign sub0_rdt = rsp_hit_s[0] ? man_rdt : '0;
    assign sub1_rdt = rsp_hit_s[1] ? man_rdt : '0;
    assign sub2_rdt = rsp_hit_s[2] ? man_rdt : '0;
    assign sub0_err = rsp_hit_s[0] & man_err;
    assign sub1_err = rsp_hit_s[1] & man_err;
    assign sub2_err = rsp_hit_s[2] & man_err;

endmodule

// File: tb/tb_tcb_arb_3mp.sv
// Directed bench for tcb_arb_3mp: a DLY=1 instance for arbitration/routing and a DLY=2 instance for delayed routing.
module tb_tcb_arb_3mp;

`ifdef TCB_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  vld, wen;
    logic [3:0]  ben [3];
    logic [31:0] adr [3];
    logic [31:0] wdt [3];
    logic [31:0] man_rdt;
    logic        man_err, man_rdy;

    logic [31:0] rdt_a [3];
    logic [2:0]  err_a, rdy_a;
    logic        mvld_a, mwen_a;
    logic [3:0]  mben_a;
    logic [31:0] madr_a, mwdt_a;

    logic [31:0] rdt_b [3];
    logic [2:0]  err_b, rdy_b;
    logic        mvld_b, mwen_b;
    logic [3:0]  mben_b;
    logic [31:0] madr_b, mwdt_b;

    tcb_arb_3mp #(.AW(32), .DW(32), .BW(4), .DLY(1), .PN(3)) dut_a (
        .clk(clk), .rst(rst),
        .sub0_vld(vld[0]), .sub0_wen(wen[0]), .sub0_ben(ben[0]), .sub0_adr(adr[0]), .sub0_wdt(wdt[0]),
        .sub0_rdt(rdt_a[0]), .sub0_err(err_a[0]), .sub0_rdy(rdy_a[0]),
        .sub1_vld(vld[1]), .sub1_wen(wen[1]), .sub1_ben(ben[1]), .sub1_adr(adr[1]), .sub1_wdt(wdt[1]),
        .sub1_rdt(rdt_a[1]), .sub1_err(err_a[1]), .sub1_rdy(rdy_a[1]),
        .sub2_vld(vld[2]), .sub2_wen(wen[2]), .sub2_ben(ben[2]), .sub2_adr(adr[2]), .sub2_wdt(wdt[2]),
        .sub2_rdt(rdt_a[2]), .sub2_err(err_a[2]), .sub2_rdy(rdy_a[2]),
        .man_vld(mvld_a), .man_wen(mwen_a), .man_ben(mben_a), .man_adr(madr_a), .man_wdt(mwdt_a),
        .man_rdt(man_rdt), .man_err(man_err), .man_rdy(man_rdy)
    );

    tcb_arb_3mp #(.AW(32), .DW(32), .BW(4), .DLY(2), .PN(3)) dut_b (
        .clk(clk), .rst(rst),
        .sub0_vld(vld[0]), .sub0_wen(wen[0]), .sub0_ben(ben[0]), .sub0_adr(adr[0]), .sub0_wdt(wdt[0]),
        .sub0_rdt(rdt_b[0]), .sub0_err(err_b[0]), .sub0_rdy(rdy_b[0]),
        .sub1_vld(vld[1]), .sub1_wen(wen[1]), .sub1_ben(ben[1]), .sub1_adr(adr[1]), .sub1_wdt(wdt[1]),
        .sub1_rdt(rdt_b[1]), .sub1_err(err_b[1]), .sub1_rdy(rdy_b[1]),
        .sub2_vld(vld[2]), .sub2_wen(wen[2]), .sub2_ben(ben[2]), .sub2_adr(adr[2]), .sub2_wdt(wdt[2]),
        .sub2_rdt(rdt_b[2]), .sub2_err(err_b[2]), .sub2_rdy(rdy_b[2]),
        .man_vld(mvld_b), .man_wen(mwen_b), .man_ben(mben_b), .man_adr(madr_b), .man_wdt(mwdt_b),
        .man_rdt(man_rdt), .man_err(man_err), .man_rdy(man_rdy)
    );

    typedef struct {
        logic [2:0]  vld;
        logic        rdy;
        logic [2:0]  exp_rdy;
        logic        exp_mvld;
        logic [31:0] exp_adr;
    } vec_t;

    vec_t tbl [12];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // contention: all request, subordinate always ready
        for (int k = 0; k < 6; k++) begin
            int idx;
            idx = RR ? (k % 3) : 0;
            tbl[k] = '{vld: 3'b111, rdy: 1'b1, exp_rdy: 3'(3'b001 << idx),
                       exp_mvld: 1'b1, exp_adr: 32'h100 * 32'(idx + 1)};
        end
        tbl[6]  = '{vld: 3'b000, rdy: 1'b1, exp_rdy: 3'b000, exp_mvld: 1'b0, exp_adr: 32'h0};
        // backpressure: port 2 stalls three cycles, port 0 joins and must wait for the lock to clear
        tbl[7]  = '{vld: 3'b100, rdy: 1'b0, exp_rdy: 3'b000, exp_mvld: 1'b1, exp_adr: 32'h300};
        tbl[8]  = '{vld: 3'b101, rdy: 1'b0, exp_rdy: 3'b000, exp_mvld: 1'b1, exp_adr: 32'h300};
        tbl[9]  = '{vld: 3'b101, rdy: 1'b0, exp_rdy: 3'b000, exp_mvld: 1'b1, exp_adr: 32'h300};
        tbl[10] = '{vld: 3'b101, rdy: 1'b1, exp_rdy: 3'b100, exp_mvld: 1'b1, exp_adr: 32'h300};
        tbl[11] = '{vld: 3'b001, rdy: 1'b1, exp_rdy: 3'b001, exp_mvld: 1'b1, exp_adr: 32'h100};

        rst = 1'b1; vld = 3'b000; wen = 3'b000; man_rdt = 32'h0; man_err = 1'b0; man_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ben[i] = 4'hF;
            adr[i] = 32'h100 * 32'(i + 1);
            wdt[i] = 32'hA000_0000 + 32'(i);
        end
        tick();
        tick();
        rst = 1'b0;
        man_rdy = 1'b1;
        @(negedge clk);
        chk("reset_rdy", 32'(rdy_a), 32'h0);
        chk("reset_mvld", 32'(mvld_a), 32'h0);
        chk("reset_rdt0", rdt_a[0], 32'h0);
        chk("reset_rdt1", rdt_a[1], 32'h0);
        chk("reset_rdt2", rdt_a[2], 32'h0);
        chk("reset_err", 32'(err_a), 32'h0);

        for (int i = 0; i < 12; i++) begin
            tick();
            vld = tbl[i].vld;
            man_rdy = tbl[i].rdy;
            @(negedge clk);
            chk($sformatf("vec%0d_rdy", i), 32'(rdy_a), 32'(tbl[i].exp_rdy));
            chk($sformatf("vec%0d_mvld", i), 32'(mvld_a), 32'(tbl[i].exp_mvld));
            if (tbl[i].exp_mvld) begin
                chk($sformatf("vec%0d_adr", i), madr_a, tbl[i].exp_adr);
            end
        end

        // single write from port 1
        tick();
        vld = 3'b010; wen = 3'b010; adr[1] = 32'h10; wdt[1] = 32'hDEADBEEF; ben[1] = 4'hF; man_rdy = 1'b1;
        @(negedge clk);
        chk("single_adr", madr_a, 32'h10);
        chk("single_wdt", mwdt_a, 32'hDEADBEEF);
        chk("single_ben", 32'(mben_a), 32'hF);
        chk("single_wen", 32'(mwen_a), 32'h1);
        chk("single_mvld", 32'(mvld_a), 32'h1);
        chk("single_rdy", 32'(rdy_a), 32'h2);
        tick();
        vld = 3'b000; wen = 3'b000;

        // read from port 1, routed after 1 cycle (dut_a) and 2 cycles (dut_b)
        tick();
        vld = 3'b010; adr[1] = 32'h20;
        @(negedge clk);
        chk("rd_rdy", 32'(rdy_a), 32'h2);
        tick();
        vld = 3'b000; man_rdt = 32'h12345678; man_err = 1'b0;
        @(negedge clk);
        chk("rd_d1_rdt1", rdt_a[1], 32'h12345678);
        chk("rd_d1_rdt0", rdt_a[0], 32'h0);
        chk("rd_d1_rdt2", rdt_a[2], 32'h0);
        chk("rd_d2_early", rdt_b[1], 32'h0);
        tick();
        man_rdt = 32'h9ABCDEF0;
        @(negedge clk);
        chk("rd_d2_rdt1", rdt_b[1], 32'h9ABCDEF0);
        chk("rd_d2_rdt0", rdt_b[0], 32'h0);
        chk("rd_d2_rdt2", rdt_b[2], 32'h0);
        chk("rd_d1_late", rdt_a[1], 32'h0);

        // back-to-back reads from ports 0 then 2, error only on the second
        tick();
        vld = 3'b001; man_rdt = 32'h0;
        @(negedge clk);
        chk("pipe_rdy0", 32'(rdy_a), 32'h1);
        tick();
        vld = 3'b100; man_rdt = 32'hAAAA0000; man_err = 1'b0;
        @(negedge clk);
        chk("pipe_rdy2", 32'(rdy_a), 32'h4);
        chk("pipe_rdt0", rdt_a[0], 32'hAAAA0000);
        chk("pipe_err_first", 32'(err_a), 32'h0);
        chk("pipe_rdt2_idle", rdt_a[2], 32'h0);
        tick();
        vld = 3'b000; man_rdt = 32'hBBBB0000; man_err = 1'b1;
        @(negedge clk);
        chk("pipe_err_second", 32'(err_a), 32'h4);
        chk("pipe_rdt2", rdt_a[2], 32'hBBBB0000);
        chk("pipe_rdt0_idle", rdt_a[0], 32'h0);

        // reset discards an outstanding response and restarts arbitration at port 0
        tick();
        man_err = 1'b0; man_rdt = 32'h0; vld = 3'b010;
        @(negedge clk);
        chk("rstq_rdy", 32'(rdy_a), 32'h2);
        tick();
        rst = 1'b1; vld = 3'b000;
        tick();
        rst = 1'b0; vld = 3'b111; man_rdt = 32'h55AA55AA;
        @(negedge clk);
        chk("rstq_discard", rdt_b[1], 32'h0);
        chk("rstq_first_gnt", 32'(rdy_a), 32'h1);

        // reset while port 2 is locked drops the lock
        tick();
        vld = 3'b100; man_rdy = 1'b0; man_rdt = 32'h0;
        @(negedge clk);
        chk("lck_stall_rdy", 32'(rdy_a), 32'h0);
        chk("lck_stall_adr", madr_a, 32'h300);
        tick();
        rst = 1'b1; vld = 3'b101;
        tick();
        rst = 1'b0; man_rdy = 1'b1;
        @(negedge clk);
        chk("lck_rst_rdy", 32'(rdy_a), 32'h1);
        chk("lck_rst_adr", madr_a, 32'h100);
        chk("lck_rst_rdt", rdt_a[2], 32'h0);

        tick();
        vld = 3'b000;
        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
